// File: rtl/ps2_typing_input.sv
// PS/2 keyboard front end: conditions the raw lines, receives frames, decodes
// make/break codes to ASCII and counts accepted keys. Macro BACKSPACE_EN enables 0x66.
module ps2_typing_input #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000,
  parameter int MAX_COUNT   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       clear,
  output logic [7:0] letter,
  output logic [7:0] counter,
  output logic       key_valid,
  output logic       frame_err
);
  localparam int FW = (FILTER_LEN  > 1) ? $clog2(FILTER_LEN)  : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

`ifdef BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  // ---------------- input conditioning ----------------
  logic [1:0]    clk_sync, dat_sync;
  logic          clk_s, dat_s, filt, flip, fall;
  logic [FW-1:0] fcnt;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];
  // filt flips on the FILTER_LEN-th consecutive sample that disagrees with it
  assign flip  = (clk_s != filt) && (fcnt == FW'(FILTER_LEN - 1));
  assign fall  = flip && filt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      fcnt     <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      if (clk_s == filt) fcnt <= '0;
      else if (flip) begin
        filt <= clk_s;
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
    end
  end

  // ---------------- receiver FSM ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_t;
  rx_t           rx_st, rx_n;
  logic [7:0]    sh, sh_n;
  logic [2:0]    bcnt, bcnt_n;
  logic          par, par_n, perr, perr_n, byte_ready, rdy_n, ferr_n;
  logic [TW-1:0] tcnt, tcnt_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_st      <= RX_IDLE;
      sh         <= '0;
      bcnt       <= '0;
      par        <= 1'b0;
      perr       <= 1'b0;
      tcnt       <= '0;
      byte_ready <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_st      <= rx_n;
      sh         <= sh_n;
      bcnt       <= bcnt_n;
      par        <= par_n;
      perr       <= perr_n;
      tcnt       <= tcnt_n;
      byte_ready <= rdy_n;
      frame_err  <= ferr_n;
    end
  end

  always_comb begin
    rx_n   = rx_st;
    sh_n   = sh;
    bcnt_n = bcnt;
    par_n  = par;
    perr_n = perr;
    rdy_n  = 1'b0;
    ferr_n = 1'b0;
    tcnt_n = (rx_st == RX_IDLE || fall) ? '0 : tcnt + 1'b1;
    if (rx_st != RX_IDLE && !fall && tcnt == TW'(TIMEOUT_CYC - 1)) begin
      ferr_n = 1'b1;
      rx_n   = RX_IDLE;
      tcnt_n = '0;
    end else if (fall) begin
      case (rx_st)
        RX_IDLE: begin
          if (dat_s) ferr_n = 1'b1;
          else begin
            rx_n   = RX_DATA;
            bcnt_n = '0;
            par_n  = 1'b0;
          end
        end
        RX_DATA: begin
          sh_n   = {dat_s, sh[7:1]};
          par_n  = par ^ dat_s;
          bcnt_n = bcnt + 1'b1;
          if (bcnt == 3'd7) rx_n = RX_PAR;
        end
        RX_PAR: begin
          perr_n = ~(par ^ dat_s);  // data + parity must hold an odd count of ones
          rx_n   = RX_STOP;
        end
        default: begin
          rx_n = RX_IDLE;
          if (dat_s && !perr) rdy_n = 1'b1;
          else ferr_n = 1'b1;
        end
      endcase
    end
  end

  // ---------------- decode FSM ----------------
  typedef enum logic [1:0] {D_MAKE, D_BREAK, D_EXT, D_EXT_BREAK} dec_t;
  dec_t       dst, dst_n;
  logic [7:0] last_make, lm_n, let_n, cnt_n;
  logic       kv_n;
  logic [8:0] m;

  // {valid, ascii} for scan-code set 2
  function automatic logic [8:0] map_code(input logic [7:0] c);
    case (c)
      8'h1C: map_code = {1'b1, 8'h41}; 8'h32: map_code = {1'b1, 8'h42};
      8'h21: map_code = {1'b1, 8'h43}; 8'h23: map_code = {1'b1, 8'h44};
      8'h24: map_code = {1'b1, 8'h45}; 8'h2B: map_code = {1'b1, 8'h46};
      8'h34: map_code = {1'b1, 8'h47}; 8'h33: map_code = {1'b1, 8'h48};
      8'h43: map_code = {1'b1, 8'h49}; 8'h3B: map_code = {1'b1, 8'h4A};
      8'h42: map_code = {1'b1, 8'h4B}; 8'h4B: map_code = {1'b1, 8'h4C};
      8'h3A: map_code = {1'b1, 8'h4D}; 8'h31: map_code = {1'b1, 8'h4E};
      8'h44: map_code = {1'b1, 8'h4F}; 8'h4D: map_code = {1'b1, 8'h50};
      8'h15: map_code = {1'b1, 8'h51}; 8'h2D: map_code = {1'b1, 8'h52};
      8'h1B: map_code = {1'b1, 8'h53}; 8'h2C: map_code = {1'b1, 8'h54};
      8'h3C: map_code = {1'b1, 8'h55}; 8'h2A: map_code = {1'b1, 8'h56};
      8'h1D: map_code = {1'b1, 8'h57}; 8'h22: map_code = {1'b1, 8'h58};
      8'h35: map_code = {1'b1, 8'h59}; 8'h1A: map_code = {1'b1, 8'h5A};
      8'h29: map_code = {1'b1, 8'h20}; 8'h5A: map_code = {1'b1, 8'h0D};
      default: map_code = 9'h000;
    endcase
  endfunction

  assign m = map_code(sh);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dst       <= D_MAKE;
      last_make <= '0;
      letter    <= '0;
      counter   <= '0;
      key_valid <= 1'b0;
    end else begin
      dst       <= dst_n;
      last_make <= lm_n;
      letter    <= let_n;
      counter   <= cnt_n;
      key_valid <= kv_n;
    end
  end

  always_comb begin
    dst_n = dst;
    lm_n  = last_make;
    let_n = letter;
    cnt_n = counter;
    kv_n  = 1'b0;
    if (byte_ready) begin
      case (dst)
        D_MAKE: begin
          if (sh == 8'hF0) dst_n = D_BREAK;
          else if (sh == 8'hE0) dst_n = D_EXT;
          else if (sh != last_make) begin  // equal code is a typematic repeat
            lm_n = sh;
            if (BS_EN && sh == 8'h66) begin
              if (counter != 8'd0) begin
                cnt_n = counter - 8'd1;
                let_n = 8'h08;
                kv_n  = 1'b1;
              end
            end else if (m[8] && counter < 8'(MAX_COUNT)) begin
              cnt_n = counter + 8'd1;
              let_n = m[7:0];
              kv_n  = 1'b1;
            end
          end
        end
        D_BREAK: begin
          if (sh == last_make) lm_n = 8'h00;
          dst_n = D_MAKE;
        end
        D_EXT:   dst_n = (sh == 8'hF0) ? D_EXT_BREAK : D_MAKE;
        default: dst_n = D_MAKE;
      endcase
    end
    if (clear) begin
      dst_n = D_MAKE;
      lm_n  = 8'h00;
      let_n = 8'h00;
      cnt_n = 8'h00;
      kv_n  = 1'b0;
    end
  end
endmodule

// File: doc/ps2_typing_input.md
Name: ps2_typing_input

Overview:
- Upstream feeder of the level display stages.
- Receives raw PS/2 keyboard serial frames, decodes make/break scan codes to ASCII, and suppresses typematic repeats.
- Presents the last accepted character on `letter` and the running keystroke count on `counter`; the level display compares both against the expected phrase.
- Level control pulses `clear` at the start of each level.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples required before filtered ps2_clk changes.
- TIMEOUT_CYC, 10000: clk cycles without a filtered ps2_clk falling edge mid-frame before the frame is aborted.
- MAX_COUNT, 15: saturation value of counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
- ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous.
- clear  input  1  synchronous level restart; clears counter, letter and decode state.
- letter  output  8  ASCII of the last accepted key; held until the next accept.
- counter  output  8  number of accepted keys since reset/clear; saturates at MAX_COUNT.
- key_valid  output  1  one-cycle pulse in the cycle letter/counter update.
- frame_err  output  1  one-cycle pulse on parity error, bad start/stop bit, or timeout.

Behaviour:
- Reset (reset=0, asynchronous): letter=0x00, counter=0, key_valid=0, frame_err=0, all FSMs idle, filtered ps2_clk=1, last_make=0x00.
- Input conditioning:
  - 2-FF synchronizer on ps2_clk and ps2_data.
  - Filtered clock toggles only after FILTER_LEN equal consecutive samples.
  - A falling edge is filtered 1->0; data is sampled in that cycle.
- Receiver FSM:
  - RX_IDLE: on falling edge, sample start bit. Start bit 1 -> frame_err pulse, stay RX_IDLE. Start bit 0 -> RX_DATA.
  - RX_DATA: 8 bits, LSB first -> RX_PAR.
  - RX_PAR: parity bit; the 9 bits must hold odd parity -> RX_STOP.
  - RX_STOP: stop bit must be 1. If the frame is good, byte_ready pulses the next cycle with the byte; otherwise frame_err pulses. Return to RX_IDLE either way.
  - Timeout: a TIMEOUT_CYC idle counter runs in any state other than RX_IDLE and resets on each falling edge. On expiry: frame_err pulse, return to RX_IDLE, partial byte discarded.
- Decode FSM, advanced on byte_ready:
  - D_MAKE: 0xF0 -> D_BREAK; 0xE0 -> D_EXT; otherwise treat as a make code.
  - D_BREAK: byte is a break code. If it equals last_make, set last_make=0x00. Go to D_MAKE; no output.
  - D_EXT: 0xF0 -> D_EXT_BREAK; any other byte ignored -> D_MAKE.
  - D_EXT_BREAK: any byte -> D_MAKE; no output.
- Make-code handling:
  - Make code equal to last_make is a typematic repeat and is ignored.
  - Otherwise last_make = code, then map.
  - Map: A-Z scan codes -> uppercase ASCII 0x41-0x5A (0x1C->A, 0x32->B, 0x24->E, 0x3C->U, ...); 0x29 -> 0x20 (space); 0x5A -> 0x0D (enter).
  - Unmapped codes update last_make but produce no accept.
- Accept:
  - Latency: key_valid asserts 2 cycles after the falling edge that samples the stop bit.
  - In that cycle letter=ASCII and counter=counter+1.
  - If counter==MAX_COUNT, the key is dropped: no key_valid, letter unchanged.
- clear: in its cycle, counter=0, letter=0x00, decode FSM=D_MAKE, last_make=0x00. The receiver is not affected.
- clear coinciding with an accept: clear wins, the key is dropped, key_valid=0.
- Mid-frame reset: everything returns to reset values immediately; the next frame is received normally.

Optional Feature:
- Macro: BACKSPACE_EN.
- Defined: make code 0x66 (backspace) accepted as ASCII 0x08.
  - counter decrements by 1, floor 0.
  - letter=0x08, key_valid pulses.
  - At counter=0: no change, no pulse.
- Undefined: 0x66 is unmapped and ignored.

Test Plan:
- Frames 0x32, 0xF0, 0x32 with correct odd parity -> one key_valid, letter=0x42, counter=1; break produces no pulse.
- Make 0x3C sent three times without break (typematic), then 0xF0 0x3C, then 0x3C -> key_valid twice total, counter=2, letter=0x55.
- 0x24 frame with parity bit flipped -> frame_err pulse, no key_valid, counter unchanged; next good 0x24 -> letter=0x45.
- 16 distinct accepted keys (alternating 0x1C/0x32 with breaks) -> counter stops at 15, 16th key gives no key_valid; clear -> counter=0, letter=0x00.
- Stop driving ps2_clk after 4 data bits for TIMEOUT_CYC+1 cycles -> frame_err pulse; following full 0x29 frame -> letter=0x20.
- reset=0 asserted mid-frame -> all outputs 0 immediately. With BACKSPACE_EN: 0x1C then 0x66 -> counter 1 then 0, letter=0x08.
